pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and stall controller for the 5-stage pipeline; it sequences the ID/EX pipeline register and its neighbours.
- Detects load-use hazards between ID/EX and IF/ID and inserts a bubble into ID/EX.
- Squashes wrong-path instructions on a taken branch resolved in EX.
- Freezes the whole pipeline while the data memory is busy, with a watchdog timeout.
- Keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- TIMEOUT, 255: maximum consecutive memory-wait cycles before error.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  5  destination register of the instruction in ID/EX.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt_i  in  1  instruction in IF/ID reads rt as a source.
- branch_taken_i  in  1  branch in EX resolved taken.
- dmem_req_i  in  1  MEM stage has an access in progress.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  clear IF/ID to NOP.
- idex_bubble_o  out  1  load zero WB/M/EX controls into ID/EX.
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- err_o  out  1  sticky memory-timeout error, registered.
- stall_cycles_o  out  CNT_W  saturating count of cycles with pc_write_o=0, registered.

## Operation
- States: RUN, MEMWAIT, ERR.
- Load-use hazard (lu) is asserted when all of these hold:
  - idex_memread_i is high;
  - idex_rt_i is not 0;
  - idex_rt_i equals ifid_rs_i, or idex_rt_i equals ifid_rt_i with ifid_uses_rt_i high.
- Default outputs: pc_write_o=1, ifid_write_o=1, all others 0.
- RUN, with priority highest first:
  - dmem_req_i & !dmem_ready_i: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1. Next state MEMWAIT, tcnt=1. If branch_taken_i is also high, set flush_pend.
  - branch_taken_i: ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1. The lu condition is ignored because its instruction is squashed.
  - lu: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
- MEMWAIT:
  - Outputs as in the RUN memory-hold case.
  - On dmem_ready_i: next state RUN. On the following cycle, if flush_pend is set, ifid_flush_o=1 and idex_bubble_o=1, then flush_pend clears.
  - Otherwise tcnt increments. When tcnt reaches TIMEOUT without ready, next state ERR.
- ERR:
  - pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, idex_bubble_o=1, err_o=1.
  - Only reset exits this state.
- stall_cycles_o increments, saturating at all-ones, on every clock edge where pc_write_o was 0 in the preceding cycle.

## Timing
- Hazard and flush outputs are Mealy outputs, combinational from state and inputs in the same cycle; there is no added latency.
- A load-use stall lasts exactly 1 cycle. On the next edge the load advances, so lu deasserts naturally.
- A memory hold covers the cycle of the request plus every cycle until the one in which dmem_ready_i=1. That ready cycle still holds; release happens on the next edge.
- dmem_ready_i in the same cycle as dmem_req_i gives no hold.
- Timeout: the ERR state is entered on the edge after TIMEOUT consecutive hold cycles.
- While rst_i=0:
  - State is RUN; tcnt, flush_pend, err_o and stall_cycles_o are all 0.
  - Combinational outputs are forced: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pipe_hold_o=0.
- Reset asserted mid-MEMWAIT or in ERR: state returns to RUN immediately, and any pending flush is dropped.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MEMWAIT, ERR};
  - REG_ZERO = 5'd0.
- Sub-module load_use_detect: purely combinational lu comparator, reused by the forwarding work.
- Top level holds the FSM, tcnt (width $clog2(TIMEOUT+1)), flush_pend and the stall counter.

## Test plan
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5.
  - Expect 1 cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - Next cycle all outputs are at defaults; stall_cycles_o=1.
- No false hazard:
  - idex_rt_i=0 with ifid_rs_i=0 gives no stall.
  - idex_rt_i=7 with ifid_rt_i=7 and ifid_uses_rt_i=0 gives no stall.
- Branch plus load-use in the same cycle: expect ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1.
- Memory wait with a pending flush:
  - Stimulus: dmem_req_i=1, ready low for 3 cycles, branch_taken_i=1 in the first cycle.
  - Expect pipe_hold_o=1 for 4 cycles.
  - On the cycle after ready, expect ifid_flush_o=1 for 1 cycle.
- Timeout: TIMEOUT=4, ready never asserted.
  - Expect ERR and err_o=1 after 4 hold cycles, staying latched.
  - Pulsing rst_i=0 clears err_o and returns to RUN.
- Counter saturation: CNT_W=4 with 20 stall cycles gives stall_cycles_o=15, with no wrap.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-control outputs of the controller.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ready_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_hold_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
    output branch_taken_i, dmem_req_i, dmem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
    input  err_o, stall_cycles_o
  );

  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
    input  branch_taken_i, dmem_req_i, dmem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
    output err_o, stall_cycles_o
  );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use comparator between the load in ID/EX and the
// source operands of the instruction in IF/ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  output logic             lu_o
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (idex_rt_i == ifid_rs_i);
  assign w_rt_match = (idex_rt_i == ifid_rt_i) & ifid_uses_rt_i;
  // r0 is hardwired zero, so a load into it never creates a dependency
  assign lu_o = idex_memread_i & (idex_rt_i != REG_ZERO) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller: load-use bubbles, branch squash, memory
// freeze with watchdog, and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipeline_ctrl_if.slave  bus
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_nxt;
  logic              r_flush_pend;
  logic              w_flush_pend_nxt;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_lu;
  logic w_mem_hold;
  logic w_squash;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_pipe_hold;

  load_use_detect u_lud (
    .idex_memread_i (bus.idex_memread_i),
    .idex_rt_i      (bus.idex_rt_i),
    .ifid_rs_i      (bus.ifid_rs_i),
    .ifid_rt_i      (bus.ifid_rt_i),
    .ifid_uses_rt_i (bus.ifid_uses_rt_i),
    .lu_o           (w_lu)
  );

  assign w_mem_hold = bus.dmem_req_i & ~bus.dmem_ready_i;
  // A flush deferred by a memory hold is treated exactly like a fresh taken branch
  assign w_squash   = bus.branch_taken_i | r_flush_pend;

  always_comb begin
    w_state_nxt      = r_state;
    w_tcnt_nxt       = r_tcnt;
    w_flush_pend_nxt = r_flush_pend;
    w_pc_write       = 1'b1;
    w_ifid_write     = 1'b1;
    w_ifid_flush     = 1'b0;
    w_idex_bubble    = 1'b0;
    w_pipe_hold      = 1'b0;

    unique case (r_state)
      RUN: begin
        if (w_mem_hold) begin
          w_pc_write       = 1'b0;
          w_ifid_write     = 1'b0;
          w_pipe_hold      = 1'b1;
          w_tcnt_nxt       = TCNT_W'(1);
          w_flush_pend_nxt = w_squash;
          if (TIMEOUT <= 1) w_state_nxt = ERR;
          else              w_state_nxt = MEMWAIT;
        end else if (w_squash) begin
          w_ifid_flush     = 1'b1;
          w_idex_bubble    = 1'b1;
          w_flush_pend_nxt = 1'b0;
        end else if (w_lu) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end
      end
      MEMWAIT: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_pipe_hold  = 1'b1;
        if (bus.dmem_ready_i) begin
          w_state_nxt = RUN;
        end else if (r_tcnt >= TCNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = ERR;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
        end
      end
      ERR: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_pipe_hold   = 1'b1;
        w_idex_bubble = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase

    // Reset forces a safe bubble into ID/EX regardless of state or inputs
    if (!rst_i) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b1;
      w_pipe_hold   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= RUN;
      r_tcnt       <= '0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_err        <= r_err | (w_state_nxt == ERR);
      if (!w_pc_write && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write_o     = w_pc_write;
  assign bus.ifid_write_o   = w_ifid_write;
  assign bus.ifid_flush_o   = w_ifid_flush;
  assign bus.idex_bubble_o  = w_idex_bubble;
  assign bus.pipe_hold_o    = w_pipe_hold;
  assign bus.err_o          = r_err;
  assign bus.stall_cycles_o = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   errors;

  pipeline_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic set_idle();
    bus.idex_memread_i = 1'b0;
    bus.idex_rt_i      = 5'd0;
    bus.ifid_rs_i      = 5'd0;
    bus.ifid_rt_i      = 5'd0;
    bus.ifid_uses_rt_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.dmem_req_i     = 1'b0;
    bus.dmem_ready_i   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    set_idle();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.dmem_req_i     = 1'b1;
    bus.branch_taken_i = 1'b1;
    #1;
    checks++; if (bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL rst_pc_write: got %b want 0", bus.pc_write_o); end
    checks++; if (bus.ifid_write_o !== 1'b0) begin errors++; $display("FAIL rst_ifid_write: got %b want 0", bus.ifid_write_o); end
    checks++; if (bus.idex_bubble_o !== 1'b1) begin errors++; $display("FAIL rst_bubble: got %b want 1", bus.idex_bubble_o); end
    checks++; if (bus.ifid_flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", bus.ifid_flush_o); end
    checks++; if (bus.pipe_hold_o !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b want 0", bus.pipe_hold_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err_o); end
    checks++; if (bus.stall_cycles_o !== 4'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", bus.stall_cycles_o); end
    @(negedge clk_i);
    set_idle();
    rst_i = 1'b1;
    #1;
    checks++; if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0)
      begin errors++; $display("FAIL post_rst_defaults: pc=%b ifid_w=%b bubble=%b want 1 1 0", bus.pc_write_o, bus.ifid_write_o, bus.idex_bubble_o); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i      = 5'd5;
    bus.ifid_rs_i      = 5'd5;
    #1;
    checks++; if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0 || bus.idex_bubble_o !== 1'b1)
      begin errors++; $display("FAIL lu_rs_stall: pc=%b ifid_w=%b bubble=%b want 0 0 1", bus.pc_write_o, bus.ifid_write_o, bus.idex_bubble_o); end
    @(negedge clk_i);
    set_idle();
    #1;
    checks++; if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0)
      begin errors++; $display("FAIL lu_release: pc=%b ifid_w=%b bubble=%b want 1 1 0", bus.pc_write_o, bus.ifid_write_o, bus.idex_bubble_o); end
    checks++; if (bus.stall_cycles_o !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cycles_o); end
    // Dependency through rt when the consumer reads rt
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i      = 5'd9;
    bus.ifid_rs_i      = 5'd3;
    bus.ifid_rt_i      = 5'd9;
    bus.ifid_uses_rt_i = 1'b1;
    #1;
    checks++; if (bus.pc_write_o !== 1'b0 || bus.idex_bubble_o !== 1'b1)
      begin errors++; $display("FAIL lu_rt_stall: pc=%b bubble=%b want 0 1", bus.pc_write_o, bus.idex_bubble_o); end
    @(negedge clk_i);
    set_idle();
    #1;
    checks++; if (bus.stall_cycles_o !== 4'd2) begin errors++; $display("FAIL lu_rt_stall_cnt: got %0d want 2", bus.stall_cycles_o); end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i      = 5'd0;
    bus.ifid_rs_i      = 5'd0;
    #1;
    checks++; if (bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0)
      begin errors++; $display("FAIL nofh_r0: pc=%b bubble=%b want 1 0", bus.pc_write_o, bus.idex_bubble_o); end
    @(negedge clk_i);
    bus.idex_rt_i      = 5'd7;
    bus.ifid_rs_i      = 5'd3;
    bus.ifid_rt_i      = 5'd7;
    bus.ifid_uses_rt_i = 1'b0;
    #1;
    checks++; if (bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0)
      begin errors++; $display("FAIL nofh_rt_unused: pc=%b bubble=%b want 1 0", bus.pc_write_o, bus.idex_bubble_o); end
    @(negedge clk_i);
    set_idle();
    #1;
    checks++; if (bus.stall_cycles_o !== 4'd0) begin errors++; $display("FAIL nofh_stall_cnt: got %0d want 0", bus.stall_cycles_o); end
  endtask

  task automatic test_branch_lu();
    do_reset();
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i      = 5'd5;
    bus.ifid_rs_i      = 5'd5;
    bus.branch_taken_i = 1'b1;
    #1;
    checks++; if (bus.ifid_flush_o !== 1'b1 || bus.idex_bubble_o !== 1'b1 || bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1)
      begin errors++; $display("FAIL br_lu: flush=%b bubble=%b pc=%b ifid_w=%b want 1 1 1 1", bus.ifid_flush_o, bus.idex_bubble_o, bus.pc_write_o, bus.ifid_write_o); end
    @(negedge clk_i);
    set_idle();
    #1;
    checks++; if (bus.ifid_flush_o !== 1'b0 || bus.stall_cycles_o !== 4'd0)
      begin errors++; $display("FAIL br_after: flush=%b cnt=%0d want 0 0", bus.ifid_flush_o, bus.stall_cycles_o); end
  endtask

  task automatic test_memwait_flush();
    logic [3:0] hold_seen;
    do_reset();
    // Cycles 1..3: ready low, branch only in cycle 1; cycle 4: ready
    for (int c = 0; c < 4; c++) begin
      bus.dmem_req_i     = 1'b1;
      bus.dmem_ready_i   = (c == 3);
      bus.branch_taken_i = (c == 0);
      #1;
      hold_seen[c] = bus.pipe_hold_o;
      checks++; if (bus.pipe_hold_o !== 1'b1 || bus.pc_write_o !== 1'b0 || bus.ifid_flush_o !== 1'b0)
        begin errors++; $display("FAIL mw_hold_c%0d: hold=%b pc=%b flush=%b want 1 0 0", c, bus.pipe_hold_o, bus.pc_write_o, bus.ifid_flush_o); end
      @(negedge clk_i);
    end
    set_idle();
    #1;
    checks++; if (bus.pipe_hold_o !== 1'b0 || bus.ifid_flush_o !== 1'b1 || bus.idex_bubble_o !== 1'b1 || bus.pc_write_o !== 1'b1)
      begin errors++; $display("FAIL mw_pend_flush: hold=%b flush=%b bubble=%b pc=%b want 0 1 1 1", bus.pipe_hold_o, bus.ifid_flush_o, bus.idex_bubble_o, bus.pc_write_o); end
    checks++; if (bus.stall_cycles_o !== 4'd4) begin errors++; $display("FAIL mw_stall_cnt: got %0d want 4 (holds %b)", bus.stall_cycles_o, hold_seen); end
    @(negedge clk_i);
    #1;
    checks++; if (bus.ifid_flush_o !== 1'b0) begin errors++; $display("FAIL mw_flush_once: got %b want 0", bus.ifid_flush_o); end
    // Ready together with the request: no hold
    bus.dmem_req_i   = 1'b1;
    bus.dmem_ready_i = 1'b1;
    #1;
    checks++; if (bus.pipe_hold_o !== 1'b0 || bus.pc_write_o !== 1'b1)
      begin errors++; $display("FAIL mw_same_cycle_ready: hold=%b pc=%b want 0 1", bus.pipe_hold_o, bus.pc_write_o); end
    // Reset mid-wait drops the pending flush
    @(negedge clk_i);
    bus.dmem_ready_i   = 1'b0;
    bus.branch_taken_i = 1'b1;
    @(negedge clk_i);
    bus.branch_taken_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    set_idle();
    #1;
    checks++; if (bus.ifid_flush_o !== 1'b0 || bus.pipe_hold_o !== 1'b0 || bus.pc_write_o !== 1'b1)
      begin errors++; $display("FAIL mw_rst_drop: flush=%b hold=%b pc=%b want 0 0 1", bus.ifid_flush_o, bus.pipe_hold_o, bus.pc_write_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.dmem_req_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.pipe_hold_o !== 1'b1 || bus.err_o !== 1'b0 || bus.idex_bubble_o !== 1'b0)
        begin errors++; $display("FAIL to_wait_c%0d: hold=%b err=%b bubble=%b want 1 0 0", c, bus.pipe_hold_o, bus.err_o, bus.idex_bubble_o); end
      @(negedge clk_i);
    end
    #1;
    checks++; if (bus.err_o !== 1'b1 || bus.pipe_hold_o !== 1'b1 || bus.idex_bubble_o !== 1'b1 || bus.pc_write_o !== 1'b0)
      begin errors++; $display("FAIL to_err: err=%b hold=%b bubble=%b pc=%b want 1 1 1 0", bus.err_o, bus.pipe_hold_o, bus.idex_bubble_o, bus.pc_write_o); end
    // Ready arriving late must not leave ERR
    bus.dmem_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    bus.dmem_req_i = 1'b0;
    #1;
    checks++; if (bus.err_o !== 1'b1 || bus.pipe_hold_o !== 1'b1)
      begin errors++; $display("FAIL to_sticky: err=%b hold=%b want 1 1", bus.err_o, bus.pipe_hold_o); end
    @(negedge clk_i);
    set_idle();
    rst_i = 1'b0;
    #1;
    checks++; if (bus.err_o !== 1'b0 || bus.stall_cycles_o !== 4'd0)
      begin errors++; $display("FAIL to_rst_clear: err=%b cnt=%0d want 0 0", bus.err_o, bus.stall_cycles_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++; if (bus.pipe_hold_o !== 1'b0 || bus.pc_write_o !== 1'b1 || bus.err_o !== 1'b0)
      begin errors++; $display("FAIL to_run_again: hold=%b pc=%b err=%b want 0 1 0", bus.pipe_hold_o, bus.pc_write_o, bus.err_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i      = 5'd12;
    bus.ifid_rs_i      = 5'd12;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (bus.stall_cycles_o !== 4'd10) begin errors++; $display("FAIL sat_mid: got %0d want 10", bus.stall_cycles_o); end
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    set_idle();
    #1;
    checks++; if (bus.stall_cycles_o !== 4'd15) begin errors++; $display("FAIL sat_20: got %0d want 15", bus.stall_cycles_o); end
    @(negedge clk_i);
    #1;
    checks++; if (bus.stall_cycles_o !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", bus.stall_cycles_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_branch_lu();
    test_memwait_flush();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
